// File: rtl/mhd_err_accum.sv
// mhd_err_accum: streaming Hamming-distance error accumulator.
// Stage 1 captures exact^approx, stage 2 registers the popcount,
// stage 3 folds the distance into saturating window statistics.
module mhd_err_accum #(
  parameter int unsigned WIDTH = 130,
  parameter int unsigned DW    = $clog2(WIDTH + 1),
  parameter int unsigned SUM_W = 32,
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [WIDTH-1:0] exact,
  input  logic [WIDTH-1:0] approx,
  input  logic [DW-1:0]    thresh,
  output logic [DW-1:0]    hd_out,
  output logic             hd_valid,
  output logic [SUM_W-1:0] sum_hd,
  output logic [DW-1:0]    max_hd,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] thr_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             sat,
  output logic             done
);

  // Popcount is split into 8-bit chunks whose partial counts are then summed.
  localparam int unsigned CHUNK  = 8;
  localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned PADW   = NCHUNK * CHUNK;
  localparam int unsigned CW     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;

  logic             accept_c;
  logic [WIDTH-1:0] s1_diff;
  logic             s1_valid;
  logic             s1_last;
  logic             s2_last;
  logic [DW-1:0]    thresh_q;

  logic [PADW-1:0]  pad_c;
  logic [CW-1:0]    chunk_c [NCHUNK];
  logic [DW-1:0]    pop_c;

  logic [SUM_W:0]   sum_nx_c;
  logic [CNT_W:0]   err_nx_c;
  logic [CNT_W:0]   thr_nx_c;
  logic [CNT_W:0]   smp_nx_c;
  logic             hd_nz_c;
  logic             hd_over_c;
  logic             sum_ovf_c;
  logic             err_ovf_c;
  logic             thr_ovf_c;
  logic             smp_ovf_c;

  // A start pulse wins over a same-cycle handshake, so that sample is dropped.
  assign accept_c = in_valid & in_ready & ~start;

  // Window control: IDLE -> RUN -> DRAIN -> DONE, start restarts from anywhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      state    <= RUN;
      in_ready <= 1'b1;
      done     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (accept_c && in_last) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          // The last sample is in stage 2 now and lands in the statistics this edge.
          if (hd_valid && s2_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        IDLE, DONE: begin
          state <= state;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Threshold is captured once per window.
  always_ff @(posedge clk) begin
    if (rst) begin
      thresh_q <= '0;
    end else if (start) begin
      thresh_q <= thresh;
    end
  end

  // Stage 1: capture the bit difference of each accepted sample.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      s1_diff  <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= accept_c;
      s1_last  <= accept_c & in_last;
      if (accept_c) begin
        s1_diff <= exact ^ approx;
      end
    end
  end

  // Single-cycle popcount tree over the stage-1 difference vector.
  always_comb begin
    pad_c = PADW'(s1_diff);
    pop_c = '0;
    for (int c = 0; c < int'(NCHUNK); c++) begin
      chunk_c[c] = '0;
    end
    for (int c = 0; c < int'(NCHUNK); c++) begin
      for (int b = 0; b < int'(CHUNK); b++) begin
        chunk_c[c] = chunk_c[c] + CW'(pad_c[c * int'(CHUNK) + b]);
      end
    end
    for (int c = 0; c < int'(NCHUNK); c++) begin
      pop_c = pop_c + DW'(chunk_c[c]);
    end
  end

  // Stage 2: publish the distance; hd_out holds the last value between samples.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      hd_out   <= '0;
      hd_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      hd_valid <= s1_valid;
      s2_last  <= s1_last;
      if (s1_valid) begin
        hd_out <= pop_c;
      end
    end
  end

  // Candidate accumulator values, one bit wider to expose overflow.
  always_comb begin
    hd_nz_c   = (hd_out != '0);
    hd_over_c = (hd_out > thresh_q);
    sum_nx_c  = {1'b0, sum_hd} + (SUM_W + 1)'(hd_out);
    err_nx_c  = {1'b0, err_cnt} + (CNT_W + 1)'(1);
    thr_nx_c  = {1'b0, thr_cnt} + (CNT_W + 1)'(1);
    smp_nx_c  = {1'b0, sample_cnt} + (CNT_W + 1)'(1);
    sum_ovf_c = sum_nx_c[SUM_W];
    err_ovf_c = hd_nz_c & err_nx_c[CNT_W];
    thr_ovf_c = hd_over_c & thr_nx_c[CNT_W];
    smp_ovf_c = smp_nx_c[CNT_W];
  end

  // Stage 3: saturating window statistics with a sticky clamp flag.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      sum_hd     <= '0;
      max_hd     <= '0;
      err_cnt    <= '0;
      thr_cnt    <= '0;
      sample_cnt <= '0;
      sat        <= 1'b0;
    end else if (hd_valid) begin
      sum_hd <= sum_ovf_c ? '1 : sum_nx_c[SUM_W-1:0];
      if (hd_out > max_hd) begin
        max_hd <= hd_out;
      end
      if (hd_nz_c) begin
        err_cnt <= err_ovf_c ? '1 : err_nx_c[CNT_W-1:0];
      end
      if (hd_over_c) begin
        thr_cnt <= thr_ovf_c ? '1 : thr_nx_c[CNT_W-1:0];
      end
      sample_cnt <= smp_ovf_c ? '1 : smp_nx_c[CNT_W-1:0];
      sat        <= sat | sum_ovf_c | err_ovf_c | thr_ovf_c | smp_ovf_c;
    end
  end

endmodule

// File: tb/tb_mhd_err_accum.sv
// tb_mhd_err_accum: directed and randomized windows against a window-level model.
// Two instances share stimulus: default widths and a narrow one that saturates.
module tb_mhd_err_accum;

  localparam int unsigned W     = 130;
  localparam int unsigned DW    = 8;
  localparam int unsigned A_SUM = 32;
  localparam int unsigned A_CNT = 24;
  localparam int unsigned B_SUM = 8;
  localparam int unsigned B_CNT = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic             in_last;
  logic [W-1:0]     exact;
  logic [W-1:0]     approx;
  logic [DW-1:0]    thresh;

  logic             a_rdy, a_hdv, a_sat, a_done;
  logic [DW-1:0]    a_hd, a_max;
  logic [A_SUM-1:0] a_sum;
  logic [A_CNT-1:0] a_err, a_thr, a_smp;

  logic             b_rdy, b_hdv, b_sat, b_done;
  logic [DW-1:0]    b_hd, b_max;
  logic [B_SUM-1:0] b_sum;
  logic [B_CNT-1:0] b_err, b_thr, b_smp;

  int     checks = 0;
  int     errors = 0;
  int     pend   = -1;
  longint thr_m  = 0;
  int     wq[$];
  int     dq[$];

  mhd_err_accum #(.WIDTH(W), .SUM_W(A_SUM), .CNT_W(A_CNT)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_rdy),
    .in_last(in_last), .exact(exact), .approx(approx), .thresh(thresh),
    .hd_out(a_hd), .hd_valid(a_hdv), .sum_hd(a_sum), .max_hd(a_max),
    .err_cnt(a_err), .thr_cnt(a_thr), .sample_cnt(a_smp), .sat(a_sat), .done(a_done)
  );

  mhd_err_accum #(.WIDTH(W), .SUM_W(B_SUM), .CNT_W(B_CNT)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_rdy),
    .in_last(in_last), .exact(exact), .approx(approx), .thresh(thresh),
    .hd_out(b_hd), .hd_valid(b_hdv), .sum_hd(b_sum), .max_hd(b_max),
    .err_cnt(b_err), .thr_cnt(b_thr), .sample_cnt(b_smp), .sat(b_sat), .done(b_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint clampw(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic bit ovf(input longint v, input int w);
    return v > ((longint'(1) << w) - 1);
  endfunction

  function automatic int rnd_dist();
    int r;
    r = int'($urandom_range(9, 0));
    if (r == 0) return 0;
    if (r == 1) return int'(W);
    return int'($urandom_range(W, 0));
  endfunction

  // Random reference vector; approx differs in exactly k distinct bit positions.
  task automatic make_pair(input int k);
    logic [W-1:0] e;
    logic [W-1:0] m;
    int           idx[W];
    int           j;
    int           t;
    for (int i = 0; i < int'(W); i++) begin
      e[i]   = 1'($urandom);
      idx[i] = i;
    end
    for (int i = 0; i < k; i++) begin
      j      = int'($urandom_range(W - 1, i));
      t      = idx[i];
      idx[i] = idx[j];
      idx[j] = t;
    end
    m = '0;
    for (int i = 0; i < k; i++) m[idx[i]] = 1'b1;
    exact  = e;
    approx = e ^ m;
  endtask

  // One clock; pend is the distance accepted at the previous edge, acc the one now presented.
  task automatic tick(input int acc);
    @(posedge clk);
    #1;
    if (pend >= 0) begin
      chk("a.hd_valid", 64'(a_hdv), 64'd1);
      chk("a.hd_out", 64'(a_hd), 64'(pend));
      chk("b.hd_valid", 64'(b_hdv), 64'd1);
      chk("b.hd_out", 64'(b_hd), 64'(pend));
    end else begin
      chk("a.hd_valid", 64'(a_hdv), 64'd0);
      chk("b.hd_valid", 64'(b_hdv), 64'd0);
    end
    pend = acc;
  endtask

  // Window statistics computed directly from the list of accepted distances.
  task automatic chk_stats(input string tag);
    longint s, mx, e, t, n;
    s = 0; mx = 0; e = 0; t = 0;
    n = longint'(wq.size());
    foreach (wq[i]) begin
      s += wq[i];
      if (wq[i] > mx) mx = wq[i];
      if (wq[i] != 0) e++;
      if (wq[i] > thr_m) t++;
    end
    chk({tag, " a.sum"}, 64'(a_sum), clampw(s, A_SUM));
    chk({tag, " a.max"}, 64'(a_max), mx);
    chk({tag, " a.err"}, 64'(a_err), clampw(e, A_CNT));
    chk({tag, " a.thr"}, 64'(a_thr), clampw(t, A_CNT));
    chk({tag, " a.smp"}, 64'(a_smp), clampw(n, A_CNT));
    chk({tag, " a.sat"}, 64'(a_sat),
        64'(ovf(s, A_SUM) | ovf(e, A_CNT) | ovf(t, A_CNT) | ovf(n, A_CNT)));
    chk({tag, " b.sum"}, 64'(b_sum), clampw(s, B_SUM));
    chk({tag, " b.max"}, 64'(b_max), mx);
    chk({tag, " b.err"}, 64'(b_err), clampw(e, B_CNT));
    chk({tag, " b.thr"}, 64'(b_thr), clampw(t, B_CNT));
    chk({tag, " b.smp"}, 64'(b_smp), clampw(n, B_CNT));
    chk({tag, " b.sat"}, 64'(b_sat),
        64'(ovf(s, B_SUM) | ovf(e, B_CNT) | ovf(t, B_CNT) | ovf(n, B_CNT)));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " a.in_ready"}, 64'(a_rdy), 64'd0);
    chk({tag, " a.done"}, 64'(a_done), 64'd0);
    chk({tag, " a.hd_out"}, 64'(a_hd), 64'd0);
    chk({tag, " b.in_ready"}, 64'(b_rdy), 64'd0);
    chk({tag, " b.done"}, 64'(b_done), 64'd0);
    chk({tag, " b.hd_out"}, 64'(b_hd), 64'd0);
    chk_stats(tag);
  endtask

  task automatic chk_done(input string tag, input logic [63:0] exp);
    chk({tag, " a.done"}, 64'(a_done), exp);
    chk({tag, " b.done"}, 64'(b_done), exp);
  endtask

  task automatic chk_ready(input string tag, input logic [63:0] exp);
    chk({tag, " a.in_ready"}, 64'(a_rdy), exp);
    chk({tag, " b.in_ready"}, 64'(b_rdy), exp);
  endtask

  task automatic do_start(input int th, input bit with_valid);
    start    = 1'b1;
    thresh   = DW'(th);
    in_valid = with_valid;
    in_last  = with_valid;
    make_pair(rnd_dist());
    pend = -1;
    tick(-1);
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    wq.delete();
    thr_m = th;
    chk_ready("start", 64'd1);
    chk_done("start", 64'd0);
    chk_stats("start");
  endtask

  // Feed dq as one window; fin follows through DRAIN/DONE and checks the result.
  task automatic run_window(input int gmin, input int gmax, input bit fin);
    int g;
    for (int i = 0; i < dq.size(); i++) begin
      g = int'($urandom_range(gmax, gmin));
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom);
        make_pair(rnd_dist());
        tick(-1);
      end
      make_pair(dq[i]);
      in_valid = 1'b1;
      in_last  = (i == dq.size() - 1);
      tick(dq[i]);
      wq.push_back(dq[i]);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (i != dq.size() - 1) chk_ready("mid", 64'd1);
    end
    if (fin) begin
      chk_ready("last.e0", 64'd0);
      chk_done("last.e0", 64'd0);
      tick(-1);
      chk_done("last.e1", 64'd0);
      tick(-1);
      chk_done("last.e2", 64'd1);
      chk_stats("window");
      for (int k = 0; k < 3; k++) begin
        in_valid = 1'b1;
        in_last  = 1'($urandom);
        make_pair(rnd_dist());
        tick(-1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk_done("done.hold", 64'd1);
      chk_ready("done.hold", 64'd0);
      chk_stats("done.hold");
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    thresh   = '0;
    exact    = '0;
    approx   = '0;

    // Reset, then idle with ignored in_valid pulses.
    pend = -1;
    tick(-1);
    tick(-1);
    rst = 1'b0;
    chk_zero("por");
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'($urandom);
      in_last  = 1'($urandom);
      make_pair(rnd_dist());
      tick(-1);
      chk_zero("idle");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    // Distances 0, 130, 5 back to back.
    do_start(64, 1'b0);
    dq = '{0, 130, 5};
    run_window(0, 0, 1'b1);

    // Gapped input, every other cycle.
    do_start(0, 1'b0);
    dq = '{1, 1, 1, 1};
    run_window(1, 1, 1'b1);

    // Start one cycle after an accept flushes the in-flight sample.
    do_start(10, 1'b0);
    make_pair(50);
    in_valid = 1'b1;
    tick(50);
    in_valid = 1'b0;
    do_start(10, 1'b0);
    tick(-1);
    chk_stats("flush.1");
    tick(-1);
    chk_stats("flush.2");
    dq = '{3, 0};
    run_window(0, 0, 1'b1);

    // Start with a same-cycle valid+last in RUN: that sample is dropped.
    do_start(20, 1'b0);
    do_start(20, 1'b1);
    tick(-1);
    tick(-1);
    chk_stats("prio");
    dq = '{9};
    run_window(0, 0, 1'b1);

    // Start during DRAIN aborts the window.
    do_start(5, 1'b0);
    dq = '{20, 40};
    run_window(0, 0, 1'b0);
    do_start(5, 1'b0);
    tick(-1);
    tick(-1);
    chk_stats("abort");
    chk_done("abort", 64'd0);

    // Saturation of the narrow instance.
    do_start(64, 1'b0);
    dq = '{130, 130};
    run_window(0, 0, 1'b1);
    do_start(64, 1'b0);
    dq = '{130, 130};
    for (int k = 0; k < 8; k++) dq.push_back(rnd_dist());
    run_window(0, 1, 1'b1);

    // Single-sample window at threshold, then reset while DONE.
    do_start(7, 1'b0);
    dq = '{7};
    run_window(0, 0, 1'b1);
    rst  = 1'b1;
    pend = -1;
    tick(-1);
    rst = 1'b0;
    wq.delete();
    chk_zero("rst.done");

    // Randomized windows.
    for (int w = 0; w < 8; w++) begin
      do_start(int'($urandom_range(140, 0)), 1'($urandom));
      dq.delete();
      for (int k = 0; k < int'($urandom_range(12, 1)); k++) dq.push_back(rnd_dist());
      run_window(0, 2, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mhd_err_accum.md
# mhd_err_accum

Streaming Hamming-distance error accumulator for approximate-circuit evaluation. It compares an exact output vector with an approximate output vector each accepted cycle, computes their per-sample Hamming distance through a pipelined popcount, and accumulates window statistics over a run of samples: total distance, maximum distance, erroneous-sample count, and over-threshold count. It sits after the simulation stimulus and DUT pair and feeds the error-metric readout.

## Interface
- `WIDTH`, 130: compared vector width; must be ≥ 1.
- `DW`, `$clog2(WIDTH+1)`: per-sample distance width (8 at the default).
- `SUM_W`, 32: total-distance accumulator width.
- `CNT_W`, 24: width of every sample counter.

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle pulse; clears statistics, flushes the pipeline, enters RUN.
- `in_valid`  in  1  sample present on `exact`/`approx`.
- `in_ready`  out  1  high only in RUN; a sample is accepted when `in_valid & in_ready`.
- `in_last`  in  1  qualifies the accepted sample as the final one of the window.
- `exact`  in  WIDTH  reference output vector.
- `approx`  in  WIDTH  approximate output vector.
- `thresh`  in  DW  distance threshold; sampled on `start` and held for the window.
- `hd_out`  out  DW  Hamming distance of the most recent sample leaving stage 2.
- `hd_valid`  out  1  `hd_out` is valid this cycle.
- `sum_hd`  out  SUM_W  sum of distances, saturating.
- `max_hd`  out  DW  largest distance seen in the window.
- `err_cnt`  out  CNT_W  samples with distance > 0, saturating.
- `thr_cnt`  out  CNT_W  samples with distance > latched threshold, saturating.
- `sample_cnt`  out  CNT_W  samples accumulated, saturating.
- `sat`  out  1  sticky; set when any accumulator clamps.
- `done`  out  1  high in DONE; statistics final and stable.

## Operation
- Pipeline stages:
  - S1 registers `exact ^ approx` plus valid and last flags.
  - S2 registers the popcount as `hd_out`/`hd_valid`; the implementation may use an adder tree internally, but it must close in one stage.
  - S3 updates the accumulators.
- Per S3 update:
  - `sum_hd += hd`
  - `max_hd = max(max_hd, hd)`
  - `err_cnt += (hd != 0)`
  - `thr_cnt += (hd > thresh_q)`
  - `sample_cnt += 1`
- All additions are unsigned. An accumulator that would exceed all-ones holds at all-ones and sets `sat`.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DRAIN when a sample is accepted with `in_last=1`.
  - DRAIN → DONE after that last sample completes its S3 update.
  - DONE → RUN on `start`.
  - `start` in any state returns to RUN. It clears the accumulators, `sat`, `hd_valid` and the pipeline valid flags (in-flight samples are discarded) and latches `thresh`.
  - `start` has priority over a same-cycle accept: that sample is discarded.
- `in_valid` while not in RUN is ignored and never counted.
- Reset values: FSM in IDLE; every output 0, including `in_ready`, `done`, `sat` and `hd_valid`. Reset mid-window discards all state.
- A window of one sample (`in_last` on the first accept) is legal.
- A distance of exactly WIDTH is representable and must not wrap.

## Timing
- Let edge E0 be the edge at which a sample is accepted.
  - The S1 register loads at E0.
  - `hd_out`/`hd_valid` are visible after E1.
  - Accumulators reflect the sample after E2.
- `hd_valid` is a one-cycle pulse per sample. Back-to-back accepts give a continuous `hd_valid` with throughput of one sample per cycle.
- Last sample accepted at E0:
  - `in_ready` drops after E0.
  - `done` rises after E2 (DRAIN lasts 2 cycles).
  - `done` stays high until `start` or `rst`.
- `start` at edge Es: `in_ready` is high and all statistics read 0 after Es.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0, `in_ready=0`, `in_valid` pulses ignored.
- `start` with thresh=64, then 3 back-to-back samples with distances 0, 130, 5, `in_last` on the third:
  - `hd_out` = 0, 130, 5 on consecutive cycles.
  - Then `done` with sum=135, max=130, err_cnt=2, thr_cnt=1, sample_cnt=3.
  - `done` is 2 cycles after the last accept.
- Gapped `in_valid` (every other cycle), 4 samples of distance 1 → sum=4, sample_cnt=4; no sample lost or double-counted.
- `start` issued one cycle after an accept in RUN → in-flight sample discarded; statistics 0 until a new sample's S3 update.
- Force `sum_hd` near max (SUM_W=8 build), feed distance 130 twice → sum_hd=255, `sat=1`, `sat` still 1 after further samples; `sample_cnt=2`.
- Single-sample window with `in_last` on the first accept, distance 7 and thresh=7 → thr_cnt=0, err_cnt=1, `done` asserted; then `rst` mid-DONE → all outputs 0 next cycle.
